// File: rtl/apb_ram_bridge.sv
// APB3/APB4 slave that turns each transfer into one single-cycle RAM request,
// with address checking, a ready-timeout and registered APB responses.
module apb_ram_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr,
    output logic                    ram_enable,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_din,
    output logic [DATA_WIDTH/8-1:0] ram_strb,
    input  logic                    ram_ready,
    input  logic [DATA_WIDTH-1:0]   ram_dout,
    output logic [1:0]              state_dbg
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RD_CAP = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Handshake: the RAM accepts a request on any edge where ram_enable and
    // ram_ready are both high; read data follows one cycle later. The APB
    // side completes on the single cycle where pready is high.

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    dropped_q, dropped_d;
    logic                    pready_d, pslverr_d, ram_enable_d, ram_we_d;
    logic [DATA_WIDTH-1:0]   prdata_d, ram_din_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_d;
    logic [SW-1:0]           ram_strb_d;
    logic                    addr_err;
    logic                    drop;

    assign addr_err  = (paddr[1:0] != 2'b00) || (paddr[ADDR_WIDTH-1 -: 2] != 2'b00);
    // Once the master abandons the transfer, the RAM side still finishes but no pready is returned.
    assign drop      = dropped_q || !psel;
    assign state_dbg = state_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dropped_d    = dropped_q;
        pready_d     = pready;
        pslverr_d    = pslverr;
        prdata_d     = prdata;
        ram_enable_d = ram_enable;
        ram_we_d     = ram_we;
        ram_addr_d   = ram_addr;
        ram_din_d    = ram_din;
        ram_strb_d   = ram_strb;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                dropped_d = 1'b0;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                if (psel && !penable) begin
                    ram_addr_d = paddr;
                    ram_din_d  = pwdata;
                    ram_we_d   = pwrite;
                    ram_strb_d = pwrite ? pstrb : '0;
                    if (addr_err) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        prdata_d  = '0;
                    end else begin
                        state_d      = REQ;
                        ram_enable_d = 1'b1;
                    end
                end
            end

            REQ: begin
                if (!psel) dropped_d = 1'b1;
                if (ram_ready) begin
                    ram_enable_d = 1'b0;
                    if (!ram_we) begin
                        state_d = RD_CAP;
                    end else if (drop) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        ram_enable_d = 1'b0;
                        if (drop) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = RESP;
                            pready_d  = 1'b1;
                            pslverr_d = 1'b1;
                            prdata_d  = '0;
                        end
                    end
                end
            end

            RD_CAP: begin
                if (drop) begin
                    state_d = IDLE;
                end else begin
                    state_d  = RESP;
                    prdata_d = ram_dout;
                    pready_d = 1'b1;
                end
            end

            RESP: begin
                state_d   = IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                cnt_d     = '0;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dropped_q  <= 1'b0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            prdata     <= '0;
            ram_enable <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_strb   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dropped_q  <= dropped_d;
            pready     <= pready_d;
            pslverr    <= pslverr_d;
            prdata     <= prdata_d;
            ram_enable <= ram_enable_d;
            ram_we     <= ram_we_d;
            ram_addr   <= ram_addr_d;
            ram_din    <= ram_din_d;
            ram_strb   <= ram_strb_d;
        end
    end

endmodule

// File: tb/tb_apb_ram_bridge.sv
// Bench for apb_ram_bridge: behavioural RAM on the ram_* port, APB driver task,
// and a word-level reference memory that predicts every read.
module tb_apb_ram_bridge;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          pready, pslverr;
    logic [DW-1:0] prdata;
    logic          ram_enable, ram_we, ram_ready;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic [SW-1:0] ram_strb;
    logic [1:0]    state_dbg;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] mem [0:(1 << (AW - 2)) - 1];
    logic [DW-1:0] ref_mem [int];

    apb_ram_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
        .prdata(prdata), .pslverr(pslverr), .ram_enable(ram_enable),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_strb(ram_strb), .ram_ready(ram_ready), .ram_dout(ram_dout),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: clears on reset, byte-strobed writes, one-cycle read latency.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << (AW - 2)); i++) mem[i] <= '0;
            ram_dout <= '0;
        end else if (ram_enable && ram_ready) begin
            if (ram_we) begin
                for (int b = 0; b < SW; b++)
                    if (ram_strb[b]) mem[ram_addr[AW-1:2]][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= mem[ram_addr[AW-1:2]];
            end
        end
    end

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        int k = int'(a[AW-1:2]);
        return ref_mem.exists(k) ? ref_mem[k] : '0;
    endfunction

    function automatic void ref_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                   input logic [SW-1:0] s);
        logic [DW-1:0] w = ref_rd(a);
        for (int b = 0; b < SW; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[int'(a[AW-1:2])] = w;
    endfunction

    function automatic logic is_bad(input logic [AW-1:0] a);
        return (a[1:0] != 2'b00) || (a[AW-1:AW-2] != 2'b00);
    endfunction

    // Called at a negedge; drives setup immediately, returns at the negedge
    // of the cycle after pready with the bus idle.
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [SW-1:0] strb,
                            output logic [DW-1:0] rdata, output logic err,
                            output int cycles, output int en_cycles,
                            output logic [SW-1:0] strb_seen);
        logic done = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge clk);
        penable = 1'b1;
        cycles = 0; en_cycles = 0; rdata = '0; err = 1'b0; strb_seen = '1;
        while (!done) begin
            cycles++;
            if (ram_enable) begin
                en_cycles++;
                strb_seen = ram_strb;
            end
            if (pready) begin
                rdata = prdata;
                err   = pslverr;
                done  = 1'b1;
            end else if (cycles >= 50) begin
                compared++; mismatched++;
                $display("FAIL xfer_timeout: addr %h got no pready after %0d cycles, need <= 50", addr, cycles);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; ram_ready = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({pready, pslverr, prdata, ram_enable, ram_we, ram_addr, ram_din, ram_strb} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got rdy=%b err=%b rd=%h en=%b we=%b a=%h d=%h s=%h, need all 0",
                     pready, pslverr, prdata, ram_enable, ram_we, ram_addr, ram_din, ram_strb);
        end
        compared++;
        if (state_dbg !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_state: got %0d need 0 (IDLE)", state_dbg);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [DW-1:0] rd; logic err; int cyc, en; logic [SW-1:0] ss;
        apb_xfer(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, rd, err, cyc, en, ss);
        ref_wr(16'h0040, 32'hDEADBEEF, 4'hF);
        compared++;
        if (cyc !== 2 || err !== 1'b0 || en !== 1) begin
            mismatched++;
            $display("FAIL wr_timing: got cyc=%0d err=%b en=%0d, need cyc=2 err=0 en=1", cyc, err, en);
        end
        apb_xfer(1'b0, 16'h0040, 32'h0, 4'hF, rd, err, cyc, en, ss);
        compared++;
        if (rd !== ref_rd(16'h0040) || err !== 1'b0) begin
            mismatched++;
            $display("FAIL rd_data: got %h err=%b, need %h err=0", rd, err, ref_rd(16'h0040));
        end
        compared++;
        if (cyc !== 3 || en !== 1 || ss !== '0) begin
            mismatched++;
            $display("FAIL rd_timing: got cyc=%0d en=%0d strb=%h, need cyc=3 en=1 strb=0", cyc, en, ss);
        end
    endtask

    task automatic test_partial_strobe();
        logic [DW-1:0] rd; logic err; int cyc, en; logic [SW-1:0] ss;
        apb_xfer(1'b1, 16'h0400, 32'h11223344, 4'hF, rd, err, cyc, en, ss);
        ref_wr(16'h0400, 32'h11223344, 4'hF);
        apb_xfer(1'b1, 16'h0400, 32'hAABBCCDD, 4'h5, rd, err, cyc, en, ss);
        ref_wr(16'h0400, 32'hAABBCCDD, 4'h5);
        compared++;
        if (ss !== 4'h5) begin
            mismatched++;
            $display("FAIL partial_strb_port: got %h need 5", ss);
        end
        apb_xfer(1'b1, 16'h0400, 32'h99999999, 4'h0, rd, err, cyc, en, ss);
        compared++;
        if (cyc !== 2 || err !== 1'b0 || en !== 1) begin
            mismatched++;
            $display("FAIL zero_strb_write: got cyc=%0d err=%b en=%0d, need 2/0/1", cyc, err, en);
        end
        apb_xfer(1'b0, 16'h0400, 32'h0, 4'h0, rd, err, cyc, en, ss);
        compared++;
        if (rd !== 32'h11BB33DD || rd !== ref_rd(16'h0400)) begin
            mismatched++;
            $display("FAIL partial_strb_data: got %h need 11bb33dd", rd);
        end
    endtask

    task automatic test_addr_errors();
        logic [DW-1:0] rd; logic err; int cyc, en; logic [SW-1:0] ss;
        apb_xfer(1'b1, 16'h0000, 32'hCAFEF00D, 4'hF, rd, err, cyc, en, ss);
        ref_wr(16'h0000, 32'hCAFEF00D, 4'hF);
        apb_xfer(1'b0, 16'h0042, 32'h0, 4'h0, rd, err, cyc, en, ss);
        compared++;
        if (cyc !== 1 || err !== 1'b1 || rd !== '0 || en !== 0) begin
            mismatched++;
            $display("FAIL misaligned_rd: got cyc=%0d err=%b rd=%h en=%0d, need 1/1/0/0", cyc, err, rd, en);
        end
        apb_xfer(1'b1, 16'h8000, 32'h12345678, 4'hF, rd, err, cyc, en, ss);
        compared++;
        if (cyc !== 1 || err !== 1'b1 || rd !== '0 || en !== 0) begin
            mismatched++;
            $display("FAIL range_wr: got cyc=%0d err=%b rd=%h en=%0d, need 1/1/0/0", cyc, err, rd, en);
        end
        apb_xfer(1'b0, 16'h0000, 32'h0, 4'h0, rd, err, cyc, en, ss);
        compared++;
        if (rd !== ref_rd(16'h0000) || err !== 1'b0) begin
            mismatched++;
            $display("FAIL range_wr_no_effect: got %h err=%b need %h err=0", rd, err, ref_rd(16'h0000));
        end
    endtask

    task automatic test_stalled_ram();
        logic [DW-1:0] rd; logic err; int cyc, en; logic [SW-1:0] ss;
        ram_ready = 1'b0;
        apb_xfer(1'b0, 16'h0040, 32'h0, 4'h0, rd, err, cyc, en, ss);
        ram_ready = 1'b1;
        compared++;
        if (en !== TO || cyc !== TO + 1 || err !== 1'b1 || rd !== '0) begin
            mismatched++;
            $display("FAIL timeout: got en=%0d cyc=%0d err=%b rd=%h, need en=%0d cyc=%0d err=1 rd=0",
                     en, cyc, err, rd, TO, TO + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rd, d; logic err; int cyc, en; logic [SW-1:0] ss;
        d = $urandom;
        apb_xfer(1'b1, 16'h0080, d, 4'hF, rd, err, cyc, en, ss);
        ref_wr(16'h0080, d, 4'hF);
        apb_xfer(1'b0, 16'h0080, 32'h0, 4'h0, rd, err, cyc, en, ss);
        compared++;
        if (rd !== ref_rd(16'h0080) || err !== 1'b0 || cyc !== 3) begin
            mismatched++;
            $display("FAIL back_to_back: got %h err=%b cyc=%0d, need %h err=0 cyc=3", rd, err, cyc, ref_rd(16'h0080));
        end
    endtask

    task automatic test_dropped_select();
        logic [DW-1:0] rd, d; logic err; int cyc, en, rdy_seen, en_seen; logic [SW-1:0] ss;
        d = $urandom;
        ram_ready = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0100; pwdata = d; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; ram_ready = 1'b1;
        rdy_seen = 0; en_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pready) rdy_seen++;
            if (ram_enable) en_seen++;
        end
        ref_wr(16'h0100, d, 4'hF);
        compared++;
        if (rdy_seen !== 0 || en_seen !== 0) begin
            mismatched++;
            $display("FAIL dropped_sel: got pready cycles=%0d enable cycles=%0d, need 0/0", rdy_seen, en_seen);
        end
        apb_xfer(1'b0, 16'h0100, 32'h0, 4'h0, rd, err, cyc, en, ss);
        compared++;
        if (rd !== ref_rd(16'h0100) || err !== 1'b0) begin
            mismatched++;
            $display("FAIL dropped_sel_write_done: got %h need %h", rd, ref_rd(16'h0100));
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] rd, d, exp; logic err, wr, bad; int cyc, en; logic [SW-1:0] ss, s;
        logic [AW-1:0] a;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       a = AW'(16'h0200 + $urandom_range(0, 31) * 4 + $urandom_range(1, 3));
                1:       a = {2'($urandom_range(1, 3)), 12'($urandom_range(0, 4095)), 2'b00};
                default: a = AW'(16'h0200 + $urandom_range(0, 31) * 4);
            endcase
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            bad = is_bad(a);
            exp = bad ? '0 : ref_rd(a);
            apb_xfer(wr, a, d, s, rd, err, cyc, en, ss);
            if (wr && !bad) ref_wr(a, d, s);
            compared++;
            if (err !== bad || cyc !== (bad ? 1 : (wr ? 2 : 3)) || en !== (bad ? 0 : 1)) begin
                mismatched++;
                $display("FAIL rand_resp[%0d]: a=%h wr=%b got err=%b cyc=%0d en=%0d, need err=%b cyc=%0d en=%0d",
                         n, a, wr, err, cyc, en, bad, bad ? 1 : (wr ? 2 : 3), bad ? 0 : 1);
            end
            if (!wr || bad) begin
                compared++;
                if (rd !== exp) begin
                    mismatched++;
                    $display("FAIL rand_rdata[%0d]: a=%h got %h need %h", n, a, rd, exp);
                end
            end
            if (!bad) begin
                compared++;
                if (ss !== (wr ? s : 4'h0)) begin
                    mismatched++;
                    $display("FAIL rand_strb[%0d]: got %h need %h", n, ss, wr ? s : 4'h0);
                end
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    task automatic test_reset_during_req();
        logic [DW-1:0] rd; logic err; int cyc, en; logic [SW-1:0] ss;
        ram_ready = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0000; pstrb = 4'h0;
        @(negedge clk);
        penable = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({pready, pslverr, prdata, ram_enable, ram_we, ram_addr, ram_din, ram_strb} !== '0
            || state_dbg !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_mid_req: got rdy=%b err=%b rd=%h en=%b a=%h state=%0d, need all 0",
                     pready, pslverr, prdata, ram_enable, ram_addr, state_dbg);
        end
        rst = 1'b0; psel = 1'b0; penable = 1'b0; ram_ready = 1'b1;
        ref_mem.delete();
        @(negedge clk);
        apb_xfer(1'b0, 16'h0000, 32'h0, 4'h0, rd, err, cyc, en, ss);
        compared++;
        if (rd !== ref_rd(16'h0000) || err !== 1'b0 || cyc !== 3) begin
            mismatched++;
            $display("FAIL post_reset_rd: got %h err=%b cyc=%0d, need %h err=0 cyc=3", rd, err, cyc, ref_rd(16'h0000));
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_addr_errors();
        test_stalled_ram();
        test_back_to_back();
        test_dropped_select();
        test_random();
        test_reset_during_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/apb_ram_bridge.md
# apb_ram_bridge

APB slave front end for the register/memory RAM block. Converts APB3/APB4 transfers (PSEL/PENABLE/PREADY/PSLVERR/PSTRB) into the RAM's single-cycle `enable`/`we`/`addr`/`din`/`strb` request port and returns RAM read data as PRDATA. It sits directly upstream of the RAM, between the APB interconnect and the RAM's `ram_*` port. It also performs address checking and a ready-timeout.

## Interface
- `DATA_WIDTH`, 32: APB and RAM data width; a multiple of 8.
- `ADDR_WIDTH`, 16: APB and RAM address width.
- `TIMEOUT`, 16: maximum number of REQ cycles with `ram_ready` low before the transfer is failed; must be ≥ 1.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `psel` in 1: APB select.
- `penable` in 1: APB access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in ADDR_WIDTH: byte address.
- `pwdata` in DATA_WIDTH: write data.
- `pstrb` in DATA_WIDTH/8: write byte strobes.
- `pready` out 1: transfer complete; registered.
- `prdata` out DATA_WIDTH: read data; registered.
- `pslverr` out 1: error response; valid only while `pready` = 1.
- `ram_enable` out 1: RAM request.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_WIDTH: RAM address.
- `ram_din` out DATA_WIDTH: RAM write data.
- `ram_strb` out DATA_WIDTH/8: RAM byte enables.
- `ram_ready` in 1: RAM accepts the request this cycle.
- `ram_dout` in DATA_WIDTH: RAM read data, valid the cycle after an accepted read.

## Operation
- **FSM states:** IDLE, REQ, RD_CAP, RESP. All outputs are registered.
- **IDLE:**
  - On `psel & !penable` (setup phase), latch `paddr`, `pwdata`, `pwrite` and `pstrb` into `ram_*`.
  - Compute the error flag: misaligned if `paddr[1:0] != 0`; out of range if `paddr[ADDR_WIDTH-1:ADDR_WIDTH-2] != 0`.
  - Error → RESP with `pslverr` = 1 and `prdata` = 0. No RAM access is made.
  - No error → REQ with `ram_enable` = 1.
- **REQ:**
  - Hold `ram_enable` and all `ram_*` fields stable.
  - `ram_ready` = 1 → drop `ram_enable`. Write goes to RESP (`pready` = 1, `pslverr` = 0). Read goes to RD_CAP.
  - `ram_ready` = 0 → increment the timeout counter. When the counter reaches TIMEOUT, drop `ram_enable` and go to RESP with `pslverr` = 1 and `prdata` = 0.
- **RD_CAP:** `prdata <= ram_dout`, then go to RESP with `pready` = 1.
- **RESP:** `pready` is high for exactly one cycle, then the FSM goes to IDLE and clears `pready`, `pslverr` and the counter. `prdata` holds its value until the next read response or error response.
- **Strobes:** on reads, `ram_strb` is driven to 0 and `pstrb` is ignored. A write with `pstrb` = 0 is still issued and completes normally; the RAM leaves its contents unchanged.
- **Dropped select:** if `psel` falls before `pready`, any RAM request already issued completes. `pready` is suppressed and the FSM returns to IDLE. There is no partial abort.
- **Back-to-back:** a new setup phase in the cycle after `pready` is sampled by IDLE normally, with no dead cycle required.

## Timing
- **Reset values:** `pready` 0, `pslverr` 0, `prdata` 0, `ram_enable` 0, `ram_we` 0, `ram_addr` 0, `ram_din` 0, `ram_strb` 0, state IDLE, counter 0.
- **Write, `ram_ready` immediate:**
  - T0: setup phase.
  - T1: `ram_enable` = 1 and the RAM writes at the end of T1.
  - T2: `pready` = 1.
  - Two-cycle access phase.
- **Read, `ram_ready` immediate:**
  - T1: `ram_enable` = 1.
  - T2: RD_CAP captures `ram_dout`.
  - T3: `pready` = 1 with valid `prdata`.
  - Three-cycle access phase.
- **Error response:** `pready` = 1 and `pslverr` = 1 in T1, a one-cycle access phase.
- **Timeout:** with `ram_ready` stuck at 0, `ram_enable` is high for TIMEOUT cycles (T1..T_TIMEOUT). `pready` and `pslverr` assert in the following cycle.
- **Reset mid-transfer:** reset returns all outputs to their reset values on the next edge, regardless of state. A RAM write already accepted is not undone.
- `ram_enable` is never high in IDLE, RD_CAP or RESP.

## Test plan
- **Write then read:** write 0xDEADBEEF to 0x0040 with `pstrb` = 0xF, then read 0x0040 → `prdata` = 0xDEADBEEF, `pslverr` = 0. The write completes in 2 access cycles and the read in 3.
- **Partial strobe:** write 0x11223344 with `pstrb` = 0xF to 0x0400, then 0xAABBCCDD with `pstrb` = 0x5, then read → 0x11BB33DD.
- **Address errors:**
  - Read 0x0042 → `pready` and `pslverr` = 1 in T1, `prdata` = 0, `ram_enable` never asserted.
  - Write 0x8000 → same response, and the RAM is unchanged (a subsequent read of 0x0000 is unchanged).
- **Stalled RAM:** with TIMEOUT = 4, force `ram_ready` = 0 → `ram_enable` is high for 4 cycles, then `pready` = 1 and `pslverr` = 1 one cycle later.
- **Back-to-back:** write 0x0080 followed immediately by a read of 0x0080 (setup in the cycle after `pready`) → correct data with no idle cycle inserted.
- **Reset during REQ:**
  - Assert `rst` during REQ of a read → next cycle all outputs are 0 and state is IDLE.
  - A following read of 0x0000 returns 0 (the RAM reset).
